// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_seq
// Purpose  : Sequential Booth multiplier for signed or unsigned WIDTH-bit
//            operands. It has valid/ready handshakes on both sides. It returns
//            the exact 2*WIDTH-bit product and a saturated fixed-point view of
//            that product.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   BOOTH_RADIX4_EN  defined   -> modified Booth radix-4. The loop runs
//                                 ceil((WIDTH+1)/2) iterations.
//                    undefined -> radix-2. The loop runs WIDTH+1 iterations.
//   Both builds give bit-identical results. Only the latency differs.
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH      operand width in bits (>=2)
//   FRAC_BITS  fractional bits per operand used for result_fx (0..WIDTH-1)
// Ports:
//   clk        in   1          clock, rising edge
//   reset      in   1          synchronous, active-high reset
//   in_valid   in   1          operands valid
//   in_ready   out  1          idle, operands can be accepted
//   in_signed  in   1          1: a,b two's complement; 0: unsigned
//   a          in   WIDTH      multiplicand
//   b          in   WIDTH      multiplier (Booth-scanned)
//   out_valid  out  1          product valid, held until accepted
//   out_ready  in   1          consumer accepts product
//   product    out  2*WIDTH    exact product a*b
//   result_fx  out  WIDTH      product >> FRAC_BITS, saturated to WIDTH bits
//   ovf        out  1          result_fx was saturated
//   busy       out  1          multiplication in progress
// ============================================================================
module booth_mul_seq #(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     result_fx,
  output logic                 ovf,
  output logic                 busy
);

  // Operands are widened by one bit. This lets unsigned inputs go through
  // the same signed Booth datapath.
  localparam int W1 = WIDTH + 1;
`ifdef BOOTH_RADIX4_EN
  localparam int SHIFT = 2;
  localparam int ITERS = (W1 + 1) / 2;
  // One extra accumulator bit holds +-2M.
  localparam int AW    = W1 + 1;
`else
  localparam int SHIFT = 1;
  localparam int ITERS = W1;
  localparam int AW    = W1;
`endif
  // The multiplier register covers every bit the recoder scans. For radix-4
  // with an odd W1, this includes one extra sign bit.
  localparam int QW    = SHIFT * ITERS;
  localparam int FW    = AW + QW;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] ITERS_C = CW'(ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [AW-1:0]        acc_q,     acc_d;     // A: high partial product
  logic [QW-1:0]        mplr_q,    mplr_d;    // Q: multiplier / low product
  logic                 q0_q,      q0_d;      // Q0: Booth history bit
  logic [AW-1:0]        mcand_q,   mcand_d;   // M: extended multiplicand
  logic                 sgn_q,     sgn_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     fx_q,      fx_d;
  logic                 ovf_q,     ovf_d;

  // --------------------------------------------------------------------------
  // Booth iteration datapath
  // --------------------------------------------------------------------------
  logic [AW-1:0]        addend_w;
  logic [AW-1:0]        acc_sum_w;
  logic [FW:0]          shifted_w;

  always_comb begin
    addend_w = '0;
`ifdef BOOTH_RADIX4_EN
    case ({mplr_q[1:0], q0_q})
      3'b001, 3'b010: addend_w = mcand_q;
      3'b011:         addend_w = mcand_q << 1;
      3'b100:         addend_w = '0 - (mcand_q << 1);
      3'b101, 3'b110: addend_w = '0 - mcand_q;
      default:        addend_w = '0;
    endcase
`else
    case ({mplr_q[0], q0_q})
      2'b01:   addend_w = mcand_q;
      2'b10:   addend_w = '0 - mcand_q;
      default: addend_w = '0;
    endcase
`endif
  end

  assign acc_sum_w = acc_q + addend_w;
  // Arithmetic shift of the whole {A,Q,Q0} chain
  assign shifted_w = $signed({acc_sum_w, mplr_q, q0_q}) >>> SHIFT;

  // --------------------------------------------------------------------------
  // Fixed-point view of the finished product
  // --------------------------------------------------------------------------
  // {A,Q} is a signed FW-bit value that is exact in both modes. Unsigned
  // products are non-negative, so an arithmetic shift gives the floor there too.
  logic [FW-1:0]        full_w;
  logic [FW-1:0]        fx_sh_w;
  logic [FW-WIDTH:0]    hi_w;
  logic [WIDTH-1:0]     fx_w;
  logic                 ovf_w;

  assign full_w  = {acc_q, mplr_q};
  assign fx_sh_w = $signed(full_w) >>> FRAC_BITS;
  assign hi_w    = fx_sh_w[FW-1:WIDTH-1];

  always_comb begin
    fx_w  = fx_sh_w[WIDTH-1:0];
    ovf_w = 1'b0;
    if (sgn_q) begin
      // The value fits only when all bits above the WIDTH-bit sign bit match it.
      if (!((&hi_w) || !(|hi_w))) begin
        ovf_w = 1'b1;
        fx_w  = fx_sh_w[FW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      if (|fx_sh_w[FW-1:WIDTH]) begin
        ovf_w = 1'b1;
        fx_w  = '1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control: next state and datapath loads
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    q0_d      = q0_q;
    mcand_d   = mcand_q;
    sgn_d     = sgn_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    fx_d      = fx_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          sgn_d   = in_signed;
          mcand_d = {{(AW-WIDTH){in_signed & a[WIDTH-1]}}, a};
          mplr_d  = {{(QW-WIDTH){in_signed & b[WIDTH-1]}}, b};
          acc_d   = '0;
          q0_d    = 1'b0;
          cnt_d   = ITERS_C;
        end
      end
      S_RUN: begin
        if (cnt_q != '0) begin
          acc_d  = shifted_w[FW:QW+1];
          mplr_d = shifted_w[QW:1];
          q0_d   = shifted_w[0];
          cnt_d  = cnt_q - CW'(1);
        end else begin
          // Results are registered one cycle after the last iteration.
          // This keeps the saturation logic off the adder path.
          state_d   = S_DONE;
          product_d = full_w[2*WIDTH-1:0];
          fx_d      = fx_w;
          ovf_d     = ovf_w;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mplr_q    <= '0;
      q0_q      <= 1'b0;
      mcand_q   <= '0;
      sgn_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      fx_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      q0_q      <= q0_d;
      mcand_q   <= mcand_d;
      sgn_q     <= sgn_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      fx_q      <= fx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign product   = product_q;
  assign result_fx = fx_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mul_seq
// Purpose  : Self-checking bench for booth_mul_seq (WIDTH=8, FRAC_BITS=4).
//            It runs directed corner cases and a randomized sweep. All results
//            are compared against an integer-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mul_seq;

  localparam int W    = 8;
  localparam int FRAC = 4;
  localparam int W1   = W + 1;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT  = (W1 + 1) / 2 + 1;
`else
  localparam int LAT  = W1 + 1;
`endif
  localparam longint SMAX = 2**(W-1) - 1;
  localparam longint SMIN = -(2**(W-1));
  localparam longint UMAX = 2**W - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic           in_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic [W-1:0]   result_fx;
  logic           ovf;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  booth_mul_seq #(.WIDTH(W), .FRAC_BITS(FRAC)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .result_fx (result_fx),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: exact product, floor shift, then clamp
  task automatic ref_model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                           input logic ms, output logic [2*W-1:0] p,
                           output logic [W-1:0] fx, output logic o);
    longint va, vb, full, sh;
    va   = ms ? longint'($signed(ma)) : longint'(ma);
    vb   = ms ? longint'($signed(mb)) : longint'(mb);
    full = va * vb;
    p    = full[2*W-1:0];
    sh   = full >>> FRAC;
    o    = 1'b0;
    fx   = W'(sh);
    if (ms) begin
      if (sh > SMAX)      begin fx = W'(SMAX); o = 1'b1; end
      else if (sh < SMIN) begin fx = W'(SMIN); o = 1'b1; end
    end else begin
      if (sh > UMAX)      begin fx = W'(UMAX); o = 1'b1; end
    end
  endtask

  // One full transaction. hold = cycles of out_ready=0 in DONE, with competing
  // operands offered; early_ready keeps out_ready high for the whole operation.
  task automatic do_op(input logic [W-1:0] opa, input logic [W-1:0] opb,
                       input logic ops, input int hold, input bit early_ready);
    logic [2*W-1:0] ep;
    logic [W-1:0]   ef;
    logic           eo;
    int             k;
    ref_model(opa, opb, ops, ep, ef, eo);
    a         = opa;
    b         = opb;
    in_signed = ops;
    in_valid  = 1'b1;
    out_ready = early_ready;
    k = 0;
    while (!in_ready && k < LAT + 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    in_signed = 1'($urandom);
    check_val("busy_after_accept", busy, 1);
    k = 0;
    while (!out_valid && k < LAT + 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("latency", k, LAT);
    check_val("product", product, ep);
    check_val("result_fx", result_fx, ef);
    check_val("ovf", ovf, eo);
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        a        = W'($urandom);
        b        = W'($urandom);
        @(posedge clk); #1;
        check_val("hold_valid", out_valid, 1);
        check_val("hold_in_ready", in_ready, 0);
        check_val("hold_product", product, ep);
        check_val("hold_fx", result_fx, ef);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("valid_drop", out_valid, 0);
    check_val("ready_rise", in_ready, 1);
    check_val("product_kept", product, ep);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [W-1:0] ra, rb;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_product", product, 0);
    check_val("rst_fx", result_fx, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_busy", busy, 0);

    // Directed cases
    do_op(8'h03, 8'hF9, 1'b1, 0, 1'b0);   // 3 * -7
    do_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0);   // unsigned saturation
    do_op(8'h80, 8'h80, 1'b1, 0, 1'b0);   // -128 * -128
    do_op(8'h18, 8'hE0, 1'b1, 0, 1'b0);   // 1.5 * -2.0
    do_op(8'hFB, 8'h04, 1'b1, 0, 1'b0);   // -5 * 4
    do_op(8'h7F, 8'h81, 1'b1, 5, 1'b0);   // back-pressure in DONE
    do_op(8'h12, 8'h34, 1'b0, 0, 1'b1);   // accepted right after handshake

    // Reset at iteration 4 discards the operation
    a = 8'h55; b = 8'h66; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("midrst_in_ready", in_ready, 1);
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_product", product, 0);
    check_val("midrst_fx", result_fx, 0);
    check_val("midrst_ovf", ovf, 0);
    check_val("midrst_busy", busy, 0);
    k = 0;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
      if (out_valid) k++;
    end
    check_val("midrst_no_valid", k, 0);
    do_op(8'hFD, 8'hFF, 1'b1, 0, 1'b0);   // -3 * -1

    // Random sweep with some corner operands mixed in
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 8'h80;
        1: rb = 8'h80;
        2: ra = 8'hFF;
        3: rb = 8'h7F;
        4: ra = 8'h00;
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)),
            1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
